// File: rtl/qdec_ctx_arbiter_pkg.sv
// Shared CABAC context types: arbiter FSM states and context memory geometry.
package qdec_cabac_package;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_INIT,
        ARB_RUN
    } t_ctx_arb_state_e;

    localparam int CTX_ADDR_W = 10;
    localparam int CTX_DATA_W = 8;

endpackage

// File: rtl/qdec_ctx_arbiter.sv
// Context-memory port owner: init sequencing, then wb-priority rd/wb arbitration.
// Define QDEC_CTX_ARB_FWD_EN to forward same-address wb data to a colliding read.
module qdec_ctx_arbiter
    import qdec_cabac_package::*;
#(
    parameter int ADDR_W  = CTX_ADDR_W,
    parameter int DATA_W  = CTX_DATA_W,
    parameter int NUM_CTX = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_start,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [DATA_W-1:0] init_data,
    input  logic              init_vld,
    output logic              init_rdy,
    output logic              init_done,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_vld,
    output logic              rd_rdy,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_data_vld,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              wb_vld,
    output logic              wb_rdy,
    output logic [ADDR_W-1:0] ctx_addr,
    output logic [DATA_W-1:0] ctx_wdata,
    output logic              ctx_we,
    output logic              ctx_re,
    input  logic [DATA_W-1:0] ctx_rdata,
    output logic              err
);

    localparam int              CNT_W   = $clog2(NUM_CTX + 1);
    localparam logic [ADDR_W:0] CTX_LIM = (ADDR_W + 1)'(NUM_CTX);
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(NUM_CTX);

    t_ctx_arb_state_e  state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              init_done_q, init_done_d;
    logic              rd_data_vld_q, rd_data_vld_d;

    logic in_init, in_run;
    logic init_acc, init_ok;
    logic rd_grant, wb_grant;

    // init_start pre-empts every handshake in its cycle so a restart never overlaps a transfer.
    assign in_init  = (state_q == ARB_INIT) && !init_start;
    assign in_run   = (state_q == ARB_RUN) && !init_start;
    assign init_acc = in_init && init_vld;
    assign init_ok  = init_acc && ({1'b0, init_addr} < CTX_LIM);
    assign wb_grant = in_run && wb_vld;

`ifdef QDEC_CTX_ARB_FWD_EN
    logic              fwd_sel_q;
    logic [DATA_W-1:0] fwd_data_q;

    assign rd_grant = in_run && rd_vld && (!wb_vld || (wb_addr == rd_addr));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_sel_q  <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            fwd_sel_q <= rd_grant && wb_vld;
            if (rd_grant && wb_vld)
                fwd_data_q <= wb_data;
        end
    end

    assign rd_data = !rd_data_vld_q ? '0 : (fwd_sel_q ? fwd_data_q : ctx_rdata);
`else
    assign rd_grant = in_run && rd_vld && !wb_vld;
    assign rd_data  = rd_data_vld_q ? ctx_rdata : '0;
`endif

    assign init_rdy    = in_init;
    assign wb_rdy      = wb_grant;
    assign rd_rdy      = rd_grant;
    assign ctx_we      = init_ok || wb_grant;
    assign ctx_re      = rd_grant && !wb_vld;
    assign init_done   = init_done_q;
    assign rd_data_vld = rd_data_vld_q;
    assign err         = err_q;

    always_comb begin
        ctx_addr  = '0;
        ctx_wdata = '0;
        if (init_ok) begin
            ctx_addr  = init_addr;
            ctx_wdata = init_data;
        end else if (wb_grant) begin
            ctx_addr  = wb_addr;
            ctx_wdata = wb_data;
        end else if (rd_grant) begin
            ctx_addr  = rd_addr;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        err_d         = err_q;
        init_done_d   = 1'b0;
        rd_data_vld_d = rd_grant;
        if (init_start) begin
            state_d = ARB_INIT;
            cnt_d   = '0;
            err_d   = 1'b0;
        end else if (state_q == ARB_INIT) begin
            if (init_acc && !init_ok)
                err_d = 1'b1;
            if (init_ok) begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_d == CNT_END) begin
                    state_d     = ARB_RUN;
                    init_done_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ARB_IDLE;
            cnt_q         <= '0;
            err_q         <= 1'b0;
            init_done_q   <= 1'b0;
            rd_data_vld_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            err_q         <= err_d;
            init_done_q   <= init_done_d;
            rd_data_vld_q <= rd_data_vld_d;
        end
    end

endmodule

// File: doc/qdec_ctx_arbiter.md
Name: qdec_ctx_arbiter

Overview:
Owns the single port of the CABAC context-state memory and shares it between three requesters:
- the context-init engine (bulk writes at slice or tile start),
- the arithmetic decoder's state fetch (reads),
- the decoder's state-update writeback (writes).

It sequences the init phase, then arbitrates reads and writebacks per cycle. Same-cycle read-after-write hazards are resolved by forwarding. It sits between qdec_ctx_fsm/Arith_decoder and qdec_ctx_mem.

Parameters:
- ADDR_W, 10, context address width.
- DATA_W, 8, context entry width (7-bit state plus MPS).
- NUM_CTX, 512, number of contexts written during init; legal addresses are 0..NUM_CTX-1.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- init_start  in  1  pulse: begin the init phase.
- init_addr  in  ADDR_W  init write address.
- init_data  in  DATA_W  init write data.
- init_vld  in  1  init write valid.
- init_rdy  out  1  init write accepted.
- init_done  out  1  one-cycle pulse: all NUM_CTX writes accepted.
- rd_addr  in  ADDR_W  state fetch address.
- rd_vld  in  1  fetch request.
- rd_rdy  out  1  fetch accepted.
- rd_data  out  DATA_W  fetched state.
- rd_data_vld  out  1  fetched state valid.
- wb_addr  in  ADDR_W  writeback address.
- wb_data  in  DATA_W  writeback data.
- wb_vld  in  1  writeback request.
- wb_rdy  out  1  writeback accepted.
- ctx_addr  out  ADDR_W  memory address.
- ctx_wdata  out  DATA_W  memory write data.
- ctx_we  out  1  memory write enable.
- ctx_re  out  1  memory read enable.
- ctx_rdata  in  DATA_W  memory read data, 1-cycle latency.
- err  out  1  sticky: out-of-range init address seen; cleared by init_start.

Behaviour:
- All handshakes are valid/ready; a transfer occurs when both are high in the same cycle. Requesters hold address and data stable while valid is high and not yet accepted.
- FSM states:
  - IDLE: rd_rdy=wb_rdy=init_rdy=0.
  - init_start moves IDLE, INIT or RUN to INIT, with cnt:=0 and err:=0.
  - INIT:
    - init_rdy=1; rd_rdy=wb_rdy=0.
    - An accepted init write with init_addr<NUM_CTX drives ctx_we=1 and cnt++.
    - An accepted init write with addr>=NUM_CTX is dropped, sets err, and does not count.
    - When cnt reaches NUM_CTX: init_done pulses in the following cycle and the FSM enters RUN.
  - RUN: init_rdy=0; rd and wb are arbitrated as below.
- RUN arbitration, one memory access per cycle, writeback has priority:
  - wb only: wb_rdy=1, ctx_we=1.
  - rd only: rd_rdy=1, ctx_re=1, ctx_addr=rd_addr.
  - wb and rd, different addresses: wb wins; rd_rdy=0, so rd stalls one cycle.
  - wb and rd, same address: wb written. With the forwarding feature, rd_rdy=1 and the read is served from wb_data with ctx_re=0. Without it, rd stalls.
- Read response:
  - rd_data_vld is high exactly one cycle after rd handshake.
  - rd_data comes from ctx_rdata, or from the registered forward data when a same-cycle forward occurred (select registered with the request).
  - Memory read-during-write is not relied on. A read one cycle after a write to the same address reads memory normally.
- Combinational outputs: rd_rdy, wb_rdy, init_rdy, ctx_* are combinational from state and valids.
- Registered outputs: rd_data, rd_data_vld, init_done and err are registered.
- Reset: state=IDLE, cnt=0, err=0, init_done=0, rd_data_vld=0, rd_data=0. All ready and ctx enables are 0. An in-flight read response is discarded.
- Boundary cases:
  - init_start during INIT restarts the count.
  - init_start in RUN still delivers an already-accepted read response in the next cycle.
  - init_start in the same cycle as an init write: the write is ignored and the count restarts at 0.
  - cnt width is clog2(NUM_CTX+1).

Optional Feature:
QDEC_CTX_ARB_FWD_EN:
- Defined: same-address wb+rd conflicts are forwarded with zero stall.
- Undefined: every wb+rd conflict stalls rd one cycle, and the forward-data register and mux are removed.

Decomposition:
- Add to qdec_cabac_package:
  - enum t_ctx_arb_state_e {ARB_IDLE, ARB_INIT, ARB_RUN};
  - localparam CTX_ADDR_W=10;
  - localparam CTX_DATA_W=8.
- No sub-module: a single module holding the FSM, arbiter and forward register.

Test Plan:
- Reset with NUM_CTX=4: init_start, then writes addr 0..3 with data 8'h10..8'h13 → init_rdy=1 throughout; init_done pulses once, the cycle after the 4th write; state RUN.
- Init write to addr 600 with NUM_CTX=512 → ctx_we=0, err=1, count unchanged; next init_start clears err.
- RUN, rd addr 2 only → ctx_re=1, ctx_addr=2; next cycle rd_data_vld=1, rd_data=8'h12.
- RUN, wb (addr 5, 8'h3A) and rd addr 9 in the same cycle → wb_rdy=1, rd_rdy=0; rd is accepted the next cycle.
- RUN, wb (addr 7, 8'h55) and rd addr 7 in the same cycle:
  - with QDEC_CTX_ARB_FWD_EN: rd_rdy=1, ctx_re=0, and next cycle rd_data=8'h55;
  - without it: rd stalls one cycle, then reads 8'h55 from memory.
- Assert rst mid-INIT with cnt=2 → all outputs 0 immediately; after release, state IDLE and rd_rdy=0 until a new init completes.
